// File: rtl/noc_pkg.sv
// Shared NoC router constants, allocator mode encoding and port-index helpers.
package noc_pkg;

   localparam int PORT_N        = 0;
   localparam int PORT_S        = 1;
   localparam int PORT_E        = 2;
   localparam int PORT_W        = 3;
   localparam int PORT_L        = 4;
   localparam int NOC_NUM_PORTS = 5;
   localparam int PTR_W_MAX     = 4;

   typedef enum logic {
      ALLOC_RR  = 1'b0,
      ALLOC_TDM = 1'b1
   } alloc_mode_e;

   // Wrap by comparing against num_ports-1 so non-power-of-2 port counts stay in range.
   function automatic logic [PTR_W_MAX-1:0] wrap_inc(input logic [PTR_W_MAX-1:0] idx,
                                                     input logic [PTR_W_MAX:0]   num_ports);
      return ({1'b0, idx} == (num_ports - 5'd1)) ? {PTR_W_MAX{1'b0}} : (idx + 4'd1);
   endfunction

endpackage

// File: rtl/noc_rr_arb.sv
// Single-output switch arbiter: round-robin with head-to-tail packet lock, or
// a request-blind TDM rotation over the inputs.
module noc_rr_arb
   import noc_pkg::*;
#(
   parameter int NUM_PORTS   = NOC_NUM_PORTS,
   parameter int OUT_IDX     = 0,
   parameter bit ALLOW_UTURN = 1'b0,
   parameter int MODE        = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic [NUM_PORTS-1:0] i_tail,
   input  logic                 i_ready,
   output logic [NUM_PORTS-1:0] o_grant
);

   localparam int                   PTR_W      = $clog2(NUM_PORTS);
   localparam logic [PTR_W_MAX:0]   NP         = (PTR_W_MAX + 1)'(NUM_PORTS);
   localparam logic [PTR_W-1:0]     OUT_P      = PTR_W'(OUT_IDX);
   localparam logic [NUM_PORTS-1:0] ONE        = {{(NUM_PORTS - 1){1'b0}}, 1'b1};
   localparam logic [NUM_PORTS-1:0] UTURN_MASK = ALLOW_UTURN ? {NUM_PORTS{1'b0}} : (ONE << OUT_IDX);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   arb_state_e           r_state;
   logic [PTR_W-1:0]     r_ptr;
   logic [PTR_W-1:0]     r_owner;
   logic                 w_release;
   logic                 w_found;
   logic                 w_hit;
   logic [NUM_PORTS-1:0] w_elig;
   logic [PTR_W-1:0]     w_start;
   logic [PTR_W-1:0]     w_idx;
   logic [PTR_W-1:0]     w_win;
   logic [PTR_W-1:0]     w_tdm_inc;
   logic [PTR_W-1:0]     w_tdm_next;

   function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] v);
      return PTR_W'(wrap_inc(PTR_W_MAX'(v), NP));
   endfunction

   // Release detection, eligible set and next TDM slot.
   // The owner's request on its release cycle is the tail being consumed, not a new packet.
   always_comb begin
      w_release  = (r_state == ST_LOCKED) && i_ready && (|(o_grant & i_req & i_tail));
      w_start    = w_release ? inc(r_owner) : r_ptr;
      w_elig     = i_req & ~UTURN_MASK & ~(w_release ? o_grant : {NUM_PORTS{1'b0}});
      w_tdm_inc  = inc(r_ptr);
      w_tdm_next = (!ALLOW_UTURN && (w_tdm_inc == OUT_P)) ? inc(w_tdm_inc) : w_tdm_inc;
   end

   // Round-robin priority search starting at w_start.
   always_comb begin
      w_found = 1'b0;
      w_hit   = 1'b0;
      w_win   = w_start;
      w_idx   = w_start;
      for (int k = 0; k < NUM_PORTS; k++) begin
         w_hit   = !w_found && w_elig[w_idx];
         w_win   = w_hit ? w_idx : w_win;
         w_found = w_found | w_hit;
         w_idx   = inc(w_idx);
      end
   end

   // Grant/lock state machine and pointer update.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_grant <= {NUM_PORTS{1'b0}};
         r_state <= ST_IDLE;
         r_ptr   <= inc(OUT_P);
         r_owner <= {PTR_W{1'b0}};
      end else if (MODE == int'(ALLOC_TDM)) begin
         o_grant <= ONE << r_ptr;
         r_ptr   <= w_tdm_next;
      end else if ((r_state == ST_IDLE) || w_release) begin
         if (w_release) begin
            r_ptr <= inc(r_owner);
         end else begin
            r_ptr <= r_ptr;
         end
         if (w_found) begin
            o_grant <= ONE << w_win;
            r_owner <= w_win;
            r_state <= ST_LOCKED;
         end else begin
            o_grant <= {NUM_PORTS{1'b0}};
            r_state <= ST_IDLE;
         end
      end else begin
         o_grant <= o_grant;
      end
   end

endmodule

// File: rtl/noc_switch_allocator.sv
// NoC router switch allocator: one noc_rr_arb per output, request transpose,
// transfer reduction to per-input grants, and requester-contract assertions.
module noc_switch_allocator
   import noc_pkg::*;
#(
   parameter int NUM_PORTS   = NOC_NUM_PORTS,
   parameter bit ALLOW_UTURN = 1'b0,
   parameter int MODE        = 0
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] in_req_i,
   input  logic [NUM_PORTS-1:0]                in_tail_i,
   input  logic [NUM_PORTS-1:0]                out_ready_i,
   output logic [NUM_PORTS-1:0][NUM_PORTS-1:0] out_grant_o,
   output logic [NUM_PORTS-1:0]                in_gnt_o
);

   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_req_t;   // [out][in]
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_xfer;    // [out][in]

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
      for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
         assign w_req_t[o][i] = in_req_i[i][o];
      end

      assign w_xfer[o] = out_grant_o[o] & w_req_t[o] & {NUM_PORTS{out_ready_i[o]}};

      noc_rr_arb #(
         .NUM_PORTS   (NUM_PORTS),
         .OUT_IDX     (o),
         .ALLOW_UTURN (ALLOW_UTURN),
         .MODE        (MODE)
      ) u_arb (
         .clk     (clk),
         .rst     (rst),
         .i_req   (w_req_t[o]),
         .i_tail  (in_tail_i),
         .i_ready (out_ready_i[o]),
         .o_grant (out_grant_o[o])
      );
   end

   // An input transfers when any output's crossbar select moves its flit.
   always_comb begin
      in_gnt_o = {NUM_PORTS{1'b0}};
      for (int o = 0; o < NUM_PORTS; o++) begin
         in_gnt_o = in_gnt_o | w_xfer[o];
      end
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chk
      a_req_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_req_i[i]));
      if (MODE == int'(ALLOC_RR)) begin : g_hold
         a_req_hold: assert property (@(posedge clk) disable iff (rst)
            ((|in_req_i[i]) && !in_gnt_o[i]) |=> $stable(in_req_i[i]));
      end
   end

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Directed, table-driven bench for noc_switch_allocator: RR lock/contention,
// U-turn masking, TDM rotation, and mid-packet reset on a 3-port instance.
module tb_noc_switch_allocator;
   import noc_pkg::*;

   logic            clk;
   logic            rst;
   logic [4:0][4:0] in_req;
   logic [4:0]      in_tail;
   logic [4:0]      out_ready;
   logic [4:0][4:0] out_grant0, out_grant_u, out_grant_t;
   logic [4:0]      in_gnt0, in_gnt_u, in_gnt_t;
   logic [2:0][2:0] req3, grant3;
   logic [2:0]      tail3, rdy3, gnt3;

   int n_cmp = 0;
   int n_bad = 0;

   noc_switch_allocator #(.NUM_PORTS(5), .ALLOW_UTURN(1'b0), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .in_req_i(in_req), .in_tail_i(in_tail), .out_ready_i(out_ready),
      .out_grant_o(out_grant0), .in_gnt_o(in_gnt0));
   noc_switch_allocator #(.NUM_PORTS(5), .ALLOW_UTURN(1'b1), .MODE(0)) dut_u (
      .clk(clk), .rst(rst), .in_req_i(in_req), .in_tail_i(in_tail), .out_ready_i(out_ready),
      .out_grant_o(out_grant_u), .in_gnt_o(in_gnt_u));
   noc_switch_allocator #(.NUM_PORTS(5), .ALLOW_UTURN(1'b0), .MODE(1)) dut_t (
      .clk(clk), .rst(rst), .in_req_i(in_req), .in_tail_i(in_tail), .out_ready_i(out_ready),
      .out_grant_o(out_grant_t), .in_gnt_o(in_gnt_t));
   noc_switch_allocator #(.NUM_PORTS(3), .ALLOW_UTURN(1'b0), .MODE(0)) dut3 (
      .clk(clk), .rst(rst), .in_req_i(req3), .in_tail_i(tail3), .out_ready_i(rdy3),
      .out_grant_o(grant3), .in_gnt_o(gnt3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [24:0] req;
      logic [4:0]  tail;
      logic [4:0]  rdy;
      int          oidx;
      logic [4:0]  egrant;
      logic [4:0]  egnt;
   } vec_t;

   typedef struct {
      logic       rst;
      logic [8:0] req;
      logic [2:0] tail;
      logic [2:0] egrant;
      logic [2:0] egnt;
   } v3_t;

   vec_t vt[$];
   v3_t  t3[$];

   function automatic logic [24:0] rq(input int i, input int o);
      logic [24:0] one;
      one = 25'd1;
      return one << (i * 5 + o);
   endfunction

   function automatic logic [8:0] rq3(input int i);
      logic [8:0] one;
      one = 9'd1;
      return one << (i * 3);
   endfunction

   function automatic logic [4:0] oh5(input int i);
      logic [4:0] one;
      one = 5'd1;
      return one << i;
   endfunction

   task automatic add(input logic r, input logic [24:0] q, input logic [4:0] t, input logic [4:0] rd,
                      input int o, input logic [4:0] eg, input logic [4:0] en);
      vec_t v;
      v.rst = r; v.req = q; v.tail = t; v.rdy = rd; v.oidx = o; v.egrant = eg; v.egnt = en;
      vt.push_back(v);
   endtask

   task automatic add3(input logic r, input logic [8:0] q, input logic [2:0] t,
                       input logic [2:0] eg, input logic [2:0] en);
      v3_t v;
      v.rst = r; v.req = q; v.tail = t; v.egrant = eg; v.egnt = en;
      t3.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      localparam logic [4:0] ALL = 5'b11111;
      localparam logic [4:0] NRL = 5'b01111;
      int ix0, ix1;

      // Test 1: single E->N packet, then S+L contention proves ptr[N] moved to W
      add(1'b0, rq(PORT_E, PORT_N), 5'b00100, ALL, PORT_N, 5'b00000, 5'b00000);
      add(1'b0, rq(PORT_E, PORT_N), 5'b00100, ALL, PORT_N, 5'b00100, 5'b00100);
      add(1'b0, rq(PORT_S, PORT_N) | rq(PORT_L, PORT_N), 5'b10010, ALL, PORT_N, 5'b00000, 5'b00000);
      add(1'b0, rq(PORT_S, PORT_N) | rq(PORT_L, PORT_N), 5'b10010, ALL, PORT_N, 5'b10000, 5'b10000);
      add(1'b0, rq(PORT_S, PORT_N), 5'b00010, ALL, PORT_N, 5'b00010, 5'b00010);
      add(1'b0, 25'd0, 5'b00000, ALL, PORT_N, 5'b00000, 5'b00000);
      // Test 2: reset, then S/E/L single-flit contention for N starting at ptr=S
      add(1'b1, 25'd0, 5'b00000, ALL, PORT_N, 5'b00000, 5'b00000);
      for (int k = 0; k < 5; k++) begin
         logic [4:0] exp_g;
         case (k)
            0:       exp_g = 5'b00000;
            1:       exp_g = 5'b00010;
            2:       exp_g = 5'b00100;
            3:       exp_g = 5'b10000;
            default: exp_g = 5'b00010;
         endcase
         add(1'b0, rq(PORT_S, PORT_N) | rq(PORT_E, PORT_N) | rq(PORT_L, PORT_N), 5'b10110, ALL,
             PORT_N, exp_g, exp_g);
      end
      add(1'b0, rq(PORT_E, PORT_N) | rq(PORT_L, PORT_N), 5'b10100, ALL, PORT_N, 5'b00100, 5'b00100);
      add(1'b0, rq(PORT_L, PORT_N), 5'b10000, ALL, PORT_N, 5'b10000, 5'b10000);
      add(1'b0, 25'd0, 5'b00000, ALL, PORT_N, 5'b00000, 5'b00000);
      // Test 3: 4-flit W->L packet held through ready stalls while S waits
      add(1'b0, rq(PORT_W, PORT_L), 5'b00000, ALL, PORT_L, 5'b00000, 5'b00000);
      add(1'b0, rq(PORT_W, PORT_L) | rq(PORT_S, PORT_L), 5'b00000, ALL, PORT_L, 5'b01000, 5'b01000);
      add(1'b0, rq(PORT_W, PORT_L) | rq(PORT_S, PORT_L), 5'b00000, NRL, PORT_L, 5'b01000, 5'b00000);
      add(1'b0, rq(PORT_W, PORT_L) | rq(PORT_S, PORT_L), 5'b00000, ALL, PORT_L, 5'b01000, 5'b01000);
      add(1'b0, rq(PORT_W, PORT_L) | rq(PORT_S, PORT_L), 5'b00000, ALL, PORT_L, 5'b01000, 5'b01000);
      add(1'b0, rq(PORT_W, PORT_L) | rq(PORT_S, PORT_L), 5'b00000, NRL, PORT_L, 5'b01000, 5'b00000);
      add(1'b0, rq(PORT_W, PORT_L) | rq(PORT_S, PORT_L), 5'b01010, ALL, PORT_L, 5'b01000, 5'b01000);
      add(1'b0, rq(PORT_S, PORT_L), 5'b00010, ALL, PORT_L, 5'b00010, 5'b00010);
      add(1'b0, 25'd0, 5'b00000, ALL, PORT_L, 5'b00000, 5'b00000);

      // Test 6 vectors: 3-port instance, reset while locked mid-packet, then wrap 2->0->1
      add3(1'b0, rq3(1), 3'b010, 3'b000, 3'b000);
      add3(1'b0, rq3(1), 3'b010, 3'b010, 3'b010);
      add3(1'b0, rq3(1), 3'b000, 3'b000, 3'b000);
      add3(1'b0, rq3(1), 3'b000, 3'b010, 3'b010);
      add3(1'b1, rq3(1), 3'b000, 3'b010, 3'b010);
      add3(1'b0, rq3(1) | rq3(2), 3'b110, 3'b000, 3'b000);
      add3(1'b0, rq3(1) | rq3(2), 3'b110, 3'b010, 3'b010);
      add3(1'b0, rq3(2), 3'b100, 3'b100, 3'b100);
      add3(1'b0, 9'd0, 3'b000, 3'b000, 3'b000);
      add3(1'b0, rq3(1) | rq3(2), 3'b110, 3'b000, 3'b000);
      add3(1'b0, rq3(1) | rq3(2), 3'b110, 3'b010, 3'b010);
      add3(1'b0, rq3(2), 3'b100, 3'b100, 3'b100);
      add3(1'b0, 9'd0, 3'b000, 3'b000, 3'b000);

      rst = 1'b1; in_req = '0; in_tail = 5'd0; out_ready = ALL;
      req3 = '0; tail3 = 3'd0; rdy3 = 3'b111;
      tick();
      tick();
      rst = 1'b0;
      #2;
      chk("reset grant dut0", 0, 32'(out_grant0), 32'd0);
      chk("reset grant dut_u", 0, 32'(out_grant_u), 32'd0);
      chk("reset grant dut_t", 0, 32'(out_grant_t), 32'd0);
      chk("reset grant dut3", 0, 32'(grant3), 32'd0);
      chk("reset in_gnt dut0", 0, 32'(in_gnt0), 32'd0);

      foreach (vt[r]) begin
         rst = vt[r].rst; in_req = vt[r].req; in_tail = vt[r].tail; out_ready = vt[r].rdy;
         #2;
         chk("row grant", r, 32'(out_grant0[vt[r].oidx]), 32'(vt[r].egrant));
         chk("row in_gnt", r, 32'(in_gnt0), 32'(vt[r].egnt));
         tick();
      end

      // Test 4: N->N request is masked without U-turn, granted with it
      in_req = rq(PORT_N, PORT_N); in_tail = 5'b00001; out_ready = ALL;
      for (int c = 0; c < 3; c++) begin
         #2;
         chk("uturn masked grant", c, 32'(out_grant0[PORT_N]), 32'd0);
         chk("uturn masked in_gnt", c, 32'(in_gnt0), 32'd0);
         chk("uturn allowed grant", c, 32'(out_grant_u[PORT_N]), (c == 1) ? 32'd1 : 32'd0);
         tick();
      end

      // Test 5: TDM rotation after reset, requests absent
      rst = 1'b1; in_req = '0; in_tail = 5'd0;
      tick();
      rst = 1'b0;
      #2;
      chk("tdm reset grant", 0, 32'(out_grant_t), 32'd0);
      ix0 = 1; ix1 = 2;
      for (int c = 0; c < 8; c++) begin
         tick();
         #2;
         chk("tdm grant S", c, 32'(out_grant_t[PORT_S]), 32'(oh5(ix1)));
         chk("tdm grant N", c, 32'(out_grant_t[PORT_N]), 32'(oh5(ix0)));
         ix1 = (ix1 + 1) % 5;
         if (ix1 == PORT_S) ix1 = (ix1 + 1) % 5;
         ix0 = (ix0 + 1) % 5;
         if (ix0 == PORT_N) ix0 = (ix0 + 1) % 5;
      end
      tick();

      // Test 6: apply 3-port vectors
      foreach (t3[r]) begin
         rst = t3[r].rst; req3 = t3[r].req; tail3 = t3[r].tail;
         #2;
         chk("p3 grant", r, 32'(grant3[0]), 32'(t3[r].egrant));
         chk("p3 in_gnt", r, 32'(gnt3), 32'(t3[r].egnt));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
